// File: rtl/fp_add_seq.sv
// Multi-cycle IEEE-754 single-precision adder: unpack, align, add/sub, normalise, pack.
// Optional macro FP_SPECIAL_EN adds NaN/Inf detection in UNPACK.
module fp_add_seq #(
  parameter int SHIFT_STEP = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ADD, NORM, DONE} state_t;

  localparam logic [7:0] STEP = 8'(SHIFT_STEP);

  state_t      state;
  logic [31:0] ra, rb;
  logic [24:0] ma, mb, sum;
  logic [7:0]  ex, diff;
  logic        sign, op;

  logic [7:0]  ea, eb, dv, sh;
  logic [23:0] fa, fb;
  logic        swap;

  always_comb begin
    ea   = ra[30:23];
    eb   = rb[30:23];
    fa   = (ea != 8'd0) ? {1'b1, ra[22:0]} : '0;
    fb   = (eb != 8'd0) ? {1'b1, rb[22:0]} : '0;
    // exponent is the more significant field, so one compare orders by magnitude
    swap = {eb, fb} > {ea, fa};
    dv   = swap ? (eb - ea) : (ea - eb);
    sh   = (diff < STEP) ? diff : STEP;
  end

`ifdef FP_SPECIAL_EN
  logic        special;
  logic [31:0] special_res;

  always_comb begin
    special = (ea == 8'hFF) || (eb == 8'hFF);
    if (((ea == 8'hFF) && (ra[22:0] != '0)) || ((eb == 8'hFF) && (rb[22:0] != '0)))
      special_res = 32'h7FC00000;
    else if ((ea == 8'hFF) && (eb == 8'hFF) && (ra[31] != rb[31]))
      special_res = 32'h7FC00000;
    else if (ea == 8'hFF)
      special_res = ra;
    else
      special_res = rb;
  end
`endif

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            ra       <= a;
            rb       <= b;
            in_ready <= 1'b0;
            state    <= UNPACK;
          end else begin
            in_ready <= 1'b1;
          end
        end
        UNPACK: begin
          sign  <= swap ? rb[31] : ra[31];
          op    <= ra[31] ^ rb[31];
          ex    <= swap ? eb : ea;
          ma    <= {1'b0, (swap ? fb : fa)};
          state <= ALIGN;
          if (dv > 8'd25) begin
            mb   <= '0;
            diff <= '0;
          end else begin
            mb   <= {1'b0, (swap ? fa : fb)};
            diff <= dv;
          end
`ifdef FP_SPECIAL_EN
          if (special) begin
            result    <= special_res;
            out_valid <= 1'b1;
            state     <= DONE;
          end
`endif
        end
        ALIGN: begin
          if (diff == 8'd0) begin
            state <= ADD;
          end else begin
            mb   <= mb >> sh;
            diff <= diff - sh;
          end
        end
        ADD: begin
          sum   <= op ? (ma - mb) : (ma + mb);
          state <= NORM;
        end
        NORM: begin
          if (sum == '0) begin
            result    <= '0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (sum[24]) begin
            if (ex >= 8'd254) begin
              result    <= {sign, 8'hFF, 23'b0};
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              sum <= sum >> 1;
              ex  <= ex + 8'd1;
            end
          end else if (!sum[23]) begin
            if (ex == 8'd1) begin
              result    <= {sign, 31'b0};
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              sum <= sum << 1;
              ex  <= ex - 8'd1;
            end
          end else begin
            result    <= {sign, ex, sum[22:0]};
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
